io_port_controller: RTL and testbench
=====================================

Name: io_port_controller

Overview:
- Peripheral on the far side of the processor's I/O pins.
- Buffers host words into an input FIFO and presents the head word on the processor's 16-bit In bus.
- Captures processor OUT writes into an output FIFO that the host drains over a valid/ready handshake.
- Generates the single-cycle Int request when fresh input arrives.

Parameters:
- AW, 2, FIFO address width; each FIFO holds DEPTH = 2**AW words (default 4).
- DW, 16, data word width; must match the processor I/O bus.

Ports:
- Clk  input  1  system clock, rising edge
- Rst  input  1  asynchronous reset, active-high
- HostInData  input  DW  word offered by host
- HostInValid  input  1  host word valid
- HostInReady  output  1  input FIFO can accept
- ProcIn  output  DW  drives processor In bus (head of input FIFO)
- ProcInRead  input  1  processor IN-instruction strobe, pops input FIFO
- ProcOut  input  DW  processor Out bus value
- ProcOutWrite  input  1  processor OUT-instruction strobe
- HostOutData  output  DW  head of output FIFO
- HostOutValid  output  1  output FIFO non-empty
- HostOutReady  input  1  host accepts head word
- Int  output  1  interrupt request to processor
- InUnderflow  output  1  sticky: ProcInRead while input FIFO empty
- OutOverflow  output  1  sticky: ProcOutWrite while output FIFO full

Behaviour:
- One clock domain. Reset is asynchronous and active-high on Rst: all pointers and counts cleared (count width AW+1), Int=0, sticky flags=0, memories not cleared.
- Reset output values: HostInReady=1, ProcIn=0, HostOutValid=0, HostOutData=0.
- Input FIFO:
  - HostInReady = !in_full, registered-state only, no dependence on ProcInRead.
  - Push on Clk edge when HostInValid & HostInReady.
  - ProcIn = mem[rd_ptr] when non-empty (show-ahead, zero latency), else 0.
  - Pop on edge when ProcInRead & !in_empty.
  - ProcInRead when empty: no pointer change, InUnderflow set.
  - Push and pop on the same edge: both occur, count unchanged.
  - When empty, a same-edge push is accepted and the pop is ignored (word not yet visible), so InUnderflow is set.
  - When full, push is blocked because ready is low; pop proceeds.
- Output FIFO:
  - Push on edge when ProcOutWrite & !out_full.
  - ProcOutWrite when full: word dropped, OutOverflow set.
  - HostOutValid = !out_empty. HostOutData = mem[rd_ptr] when valid, else 0.
  - Pop on edge when HostOutValid & HostOutReady.
  - Push and pop on the same edge are allowed at any non-boundary count. At full, the pop proceeds and the push is still dropped, because full is evaluated pre-edge.
- Pointers wrap modulo DEPTH. Full is count==DEPTH; empty is count==0.
- Sticky flags clear only on Rst.
- Int: registered. Set for exactly one cycle following an edge at which a word was pushed into an empty input FIFO (in_count==0 & push). Otherwise 0.
- Back-to-back pushes into a non-empty FIFO raise no Int.
- Reset mid-operation aborts everything immediately: FIFOs become empty and any pending Int pulse is cancelled.

Optional Feature:
- Macro: IO_PORT_INT_EN.
- Defined: Int behaves as above.
- Undefined: Int is tied constantly to 0, and the edge-detect logic is not built. The processor then polls the port; all FIFO behaviour is unchanged.

Test Plan:
- Reset with Rst pulsed mid-cycle (async) -> HostInReady=1, ProcIn=0, HostOutValid=0, Int=0, flags 0, with no clock edge needed.
- Host pushes 16'h1234 into empty FIFO -> ProcIn=16'h1234 the same cycle after the edge, and Int=1 for exactly one cycle. Then push 16'h5678 -> no Int. ProcInRead one cycle -> ProcIn=16'h5678.
- Push 4 words 16'h0001..16'h0004 (AW=2) -> HostInReady=0. Fifth HostInValid is not accepted. Pop all four -> values in order, wrap verified on refill with 16'hAAAA.
- ProcInRead with FIFO empty -> ProcIn stays 0, InUnderflow=1 and remains 1 until Rst.
- ProcOutWrite of 16'hBEEF and 16'hCAFE with HostOutReady=0 -> HostOutValid=1, HostOutData=16'hBEEF. HostOutReady=1 for two cycles -> 16'hBEEF then 16'hCAFE, then valid=0.
- Fill output FIFO to 4 words, then ProcOutWrite 16'hDEAD with a simultaneous host pop -> head popped, 16'hDEAD dropped, OutOverflow=1, count=3.

Source files
------------

// File: rtl/io_port_controller.sv
// Host-side I/O port: input FIFO feeding the processor In bus, output FIFO drained by the host.
// Optional macro IO_PORT_INT_EN builds the one-cycle Int pulse on fresh input; otherwise Int is tied low.
module io_port_controller #(
  parameter int AW = 2,
  parameter int DW = 16
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic [DW-1:0] HostInData,
  input  logic          HostInValid,
  output logic          HostInReady,
  output logic [DW-1:0] ProcIn,
  input  logic          ProcInRead,
  input  logic [DW-1:0] ProcOut,
  input  logic          ProcOutWrite,
  output logic [DW-1:0] HostOutData,
  output logic          HostOutValid,
  input  logic          HostOutReady,
  output logic          Int,
  output logic          InUnderflow,
  output logic          OutOverflow
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] in_mem  [DEPTH];
  logic [DW-1:0] out_mem [DEPTH];

  logic [AW-1:0] in_wr_ptr, in_rd_ptr, out_wr_ptr, out_rd_ptr;
  logic [AW:0]   in_count, out_count;
  logic          in_empty, in_full, out_empty, out_full;
  logic          in_push, in_pop, out_push, out_pop;

  always_comb begin
    in_empty  = (in_count == '0);
    in_full   = (in_count == FULL_CNT);
    out_empty = (out_count == '0);
    out_full  = (out_count == FULL_CNT);
    in_push   = HostInValid && !in_full;
    in_pop    = ProcInRead && !in_empty;
    out_push  = ProcOutWrite && !out_full;
    out_pop   = HostOutReady && !out_empty;
  end

  assign HostInReady  = !in_full;
  assign ProcIn       = in_empty ? '0 : in_mem[in_rd_ptr];
  assign HostOutValid = !out_empty;
  assign HostOutData  = out_empty ? '0 : out_mem[out_rd_ptr];

  // Storage is intentionally left out of reset; only pointers and counts are cleared.
  always_ff @(posedge Clk) begin
    if (in_push)  in_mem[in_wr_ptr]   <= HostInData;
    if (out_push) out_mem[out_wr_ptr] <= ProcOut;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      in_wr_ptr   <= '0;
      in_rd_ptr   <= '0;
      in_count    <= '0;
      InUnderflow <= 1'b0;
    end else begin
      if (in_push) in_wr_ptr <= in_wr_ptr + AW'(1);
      if (in_pop)  in_rd_ptr <= in_rd_ptr + AW'(1);
      case ({in_push, in_pop})
        2'b10:   in_count <= in_count + (AW+1)'(1);
        2'b01:   in_count <= in_count - (AW+1)'(1);
        default: in_count <= in_count;
      endcase
      if (ProcInRead && in_empty) InUnderflow <= 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      out_wr_ptr  <= '0;
      out_rd_ptr  <= '0;
      out_count   <= '0;
      OutOverflow <= 1'b0;
    end else begin
      if (out_push) out_wr_ptr <= out_wr_ptr + AW'(1);
      if (out_pop)  out_rd_ptr <= out_rd_ptr + AW'(1);
      case ({out_push, out_pop})
        2'b10:   out_count <= out_count + (AW+1)'(1);
        2'b01:   out_count <= out_count - (AW+1)'(1);
        default: out_count <= out_count;
      endcase
      if (ProcOutWrite && out_full) OutOverflow <= 1'b1;
    end
  end

`ifdef IO_PORT_INT_EN
  logic int_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) int_q <= 1'b0;
    else     int_q <= in_push && in_empty;
  end

  assign Int = int_q;
`else
  assign Int = 1'b0;
`endif

endmodule

// File: tb/tb_io_port_controller.sv
// Scoreboard bench for io_port_controller: queue-based reference model predicts post-edge outputs,
// a monitor pops each prediction and compares it against the DUT.
module tb_io_port_controller;

  localparam int AW    = 2;
  localparam int DW    = 16;
  localparam int DEPTH = 2 ** AW;
`ifdef IO_PORT_INT_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic [DW-1:0] HostInData = '0;
  logic          HostInValid = 1'b0;
  logic          HostInReady;
  logic [DW-1:0] ProcIn;
  logic          ProcInRead = 1'b0;
  logic [DW-1:0] ProcOut = '0;
  logic          ProcOutWrite = 1'b0;
  logic [DW-1:0] HostOutData;
  logic          HostOutValid;
  logic          HostOutReady = 1'b0;
  logic          Int;
  logic          InUnderflow;
  logic          OutOverflow;

  always #5 Clk = ~Clk;

  io_port_controller #(.AW(AW), .DW(DW)) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .HostInData   (HostInData),
    .HostInValid  (HostInValid),
    .HostInReady  (HostInReady),
    .ProcIn       (ProcIn),
    .ProcInRead   (ProcInRead),
    .ProcOut      (ProcOut),
    .ProcOutWrite (ProcOutWrite),
    .HostOutData  (HostOutData),
    .HostOutValid (HostOutValid),
    .HostOutReady (HostOutReady),
    .Int          (Int),
    .InUnderflow  (InUnderflow),
    .OutOverflow  (OutOverflow)
  );

  typedef struct {
    logic          rdy;
    logic [DW-1:0] pin;
    logic          ovalid;
    logic [DW-1:0] odata;
    logic          irq;
    logic          uf;
    logic          of;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] m_in[$];
  logic [DW-1:0] m_out[$];
  bit            m_uf = 1'b0;
  bit            m_of = 1'b0;
  event          chk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic exp_t snapshot(input bit irq);
    exp_t e;
    e.rdy    = (m_in.size() < DEPTH);
    e.pin    = (m_in.size() > 0) ? m_in[0] : '0;
    e.ovalid = (m_out.size() > 0);
    e.odata  = (m_out.size() > 0) ? m_out[0] : '0;
    e.irq    = irq;
    e.uf     = m_uf;
    e.of     = m_of;
    return e;
  endfunction

  // Monitor: one prediction per post-edge sample or per asynchronous reset check.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk or chk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("HostInReady",  DW'(HostInReady),  DW'(e.rdy));
        check("ProcIn",       ProcIn,            e.pin);
        check("HostOutValid", DW'(HostOutValid), DW'(e.ovalid));
        check("HostOutData",  HostOutData,       e.odata);
        check("Int",          DW'(Int),          DW'(e.irq));
        check("InUnderflow",  DW'(InUnderflow),  DW'(e.uf));
        check("OutOverflow",  DW'(OutOverflow),  DW'(e.of));
      end
    end
  end

  // Called one time unit after a rising edge; applies inputs across the next edge.
  task automatic step(input logic hv, input logic [DW-1:0] hd, input logic rd,
                      input logic ow, input logic [DW-1:0] od, input logic hr);
    bit push_in, was_empty, out_full;
    exp_t e;
    HostInValid  = hv;
    HostInData   = hd;
    ProcInRead   = rd;
    ProcOutWrite = ow;
    ProcOut      = od;
    HostOutReady = hr;

    was_empty = (m_in.size() == 0);
    push_in   = hv && (m_in.size() < DEPTH);
    if (rd && was_empty) m_uf = 1'b1;
    else if (rd)         void'(m_in.pop_front());
    if (push_in) m_in.push_back(hd);

    out_full = (m_out.size() == DEPTH);
    if (hr && m_out.size() > 0) void'(m_out.pop_front());
    if (ow) begin
      if (out_full) m_of = 1'b1;
      else          m_out.push_back(od);
    end

    e = snapshot(INT_EN && push_in && was_empty);
    @(posedge Clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  // Raises Rst away from any clock edge and checks outputs before the next edge.
  task automatic do_reset();
    @(negedge Clk);
    #2;
    Rst          = 1'b1;
    HostInValid  = 1'b0;
    ProcInRead   = 1'b0;
    ProcOutWrite = 1'b0;
    HostOutReady = 1'b0;
    m_in.delete();
    m_out.delete();
    m_uf = 1'b0;
    m_of = 1'b0;
    exp_q.push_back(snapshot(1'b0));
    ->chk;
    #2;
    Rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;
    do_reset();

    // Fresh word into empty FIFO, then a second word, then reads.
    step(1'b1, 16'h1234, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 16'h5678, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);

    // Fill, blocked fifth push, drain, wrap refill.
    for (int i = 1; i <= 4; i++) step(1'b1, DW'(i), 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 16'h0005, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 16'h0006, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 16'hAAAA, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);

    // Underflow, including same-edge push into an empty FIFO.
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    idle();
    step(1'b1, 16'h7777, 1'b1, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);

    // Output FIFO ordering.
    step(1'b0, '0, 1'b0, 1'b1, 16'hBEEF, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 16'hCAFE, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    idle();

    // Overflow with simultaneous host pop at full.
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1, DW'(16'h1000 + i), 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 16'hDEAD, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1, 16'h2000, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);

    // Reset cancels a pending Int and empties both FIFOs.
    do_reset();
    step(1'b1, 16'h4242, 1'b0, 1'b1, 16'h2424, 1'b0);
    do_reset();
    idle();

    for (int i = 0; i < 300; i++) begin
      step(1'($urandom % 2), DW'($urandom), 1'(($urandom % 3) == 0),
           1'(($urandom % 3) == 0), DW'($urandom), 1'($urandom % 2));
      if (i == 150) do_reset();
    end

    @(negedge Clk);
    #2;
    check("scoreboard_drained", DW'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
